// File: rtl/serializer_pkg.sv
// Shared types and limits for the bit serializer.
package serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_PARITY = 2'b10
    } ser_state_t;

    localparam int unsigned SER_MAX_W = 32;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector one bit per clock.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    ser_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ser_bit;
    logic              last_data;
    logic              accept;
`ifdef SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    assign ser_bit   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign last_data = (state_q == S_SHIFT) && (cnt_q == LastCnt);
    assign out_valid = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;

    // in_ready is a pure state decode so it never depends on in_valid.
`ifdef SERIALIZER_PARITY_EN
    assign in_ready  = (state_q == S_IDLE) || (state_q == S_PARITY);
    assign out_last  = (state_q == S_PARITY);
`else
    assign in_ready  = (state_q == S_IDLE) || last_data;
    assign out_last  = last_data;
`endif

    always_comb begin
        out_bit = 1'b0;
        unique case (state_q)
            S_SHIFT:  out_bit = ser_bit;
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: out_bit = par_q;
`endif
            default:  out_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, shreg_q[DATA_W-1:1]};
                cnt_d   = cnt_q + 1'b1;
`ifdef SERIALIZER_PARITY_EN
                par_d   = par_q ^ ser_bit;
`endif
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = accept ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: begin
                state_d = accept ? S_SHIFT : S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A new word always restarts the frame bookkeeping.
        if (accept) begin
            shreg_d = in_data;
            cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            par_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance, DATA_W=8.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       valid_m = 1'b0, valid_l = 1'b0;
    logic       ready_m, bit_m, ovalid_m, last_m, busy_m;
    logic       ready_l, bit_l, ovalid_l, last_l, busy_l;

    int total = 0;
    int bad   = 0;

    // Observed vector layout: {out_valid, out_bit, out_last, in_ready, busy}
    logic [4:0] got, exp;
    localparam logic [4:0] IdleVec = 5'b00010;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid_m),
        .in_ready(ready_m), .out_bit(bit_m), .out_valid(ovalid_m),
        .out_last(last_m), .busy(busy_m)
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid_l),
        .in_ready(ready_l), .out_bit(bit_l), .out_valid(ovalid_l),
        .out_last(last_l), .busy(busy_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL reset_msb: got %b want %b", got, IdleVec);
        end
        got = {ovalid_l, bit_l, last_l, ready_l, busy_l};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL reset_lsb: got %b want %b", got, IdleVec);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // 8'hB4 MSB first: 1,0,1,1,0,1,0,0 then parity 0
    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hB4;
        in_data = w;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            exp = {1'b1, (i <= 8) ? w[8-i] : 1'b0, i == FL, i == FL, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL msb_b4 cycle %0d: got %b want %b", i, got, exp);
            end
            tick();
        end
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL msb_b4_idle: got %b want %b", got, IdleVec);
        end
    endtask

    // 8'h01 LSB first: 1 then seven 0s, parity 1
    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        in_data = w;
        valid_l = 1'b1;
        tick();
        valid_l = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            exp = {1'b1, (i <= 8) ? w[i-1] : 1'b1, i == FL, i == FL, 1'b1};
            got = {ovalid_l, bit_l, last_l, ready_l, busy_l};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL lsb_01 cycle %0d: got %b want %b", i, got, exp);
            end
            tick();
        end
        got = {ovalid_l, bit_l, last_l, ready_l, busy_l};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL lsb_01_idle: got %b want %b", got, IdleVec);
        end
    endtask

    // 8'hFF then 8'h00 with in_valid held: contiguous stream, no gap
    task automatic test_back_to_back();
        int p;
        in_data = 8'hFF;
        valid_m = 1'b1;
        tick();
        in_data = 8'h00;
        for (int i = 1; i <= 2 * FL; i++) begin
            p = (i <= FL) ? i : i - FL;
            exp = {1'b1, i <= 8, p == FL, p == FL, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL b2b cycle %0d: got %b want %b", i, got, exp);
            end
            tick();
            if (i == FL) valid_m = 1'b0;
        end
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL b2b_idle: got %b want %b", got, IdleVec);
        end
    endtask

    // 8'h55 offered mid-frame must wait and then be emitted intact
    task automatic test_hold_off();
        logic [7:0] w, w2;
        w  = 8'hB4;
        w2 = 8'h55;
        in_data = w;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            exp = {1'b1, (i <= 8) ? w[8-i] : 1'b0, i == FL, i == FL, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL holdoff_b4 cycle %0d: got %b want %b", i, got, exp);
            end
            if (i == 1) begin
                in_data = w2;
                valid_m = 1'b1;
            end
            tick();
        end
        valid_m = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            exp = {1'b1, (i <= 8) ? w2[8-i] : 1'b0, i == FL, i == FL, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL holdoff_55 cycle %0d: got %b want %b", i, got, exp);
            end
            tick();
        end
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL holdoff_idle: got %b want %b", got, IdleVec);
        end
    endtask

    // 8'h07: odd weight, so the parity bit (when present) is 1
    task automatic test_parity();
        logic [7:0] w;
        w = 8'h07;
        in_data = w;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            exp = {1'b1, (i <= 8) ? w[8-i] : 1'b1, i == FL, i == FL, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL parity_07 cycle %0d: got %b want %b", i, got, exp);
            end
            tick();
        end
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL parity_07_idle: got %b want %b", got, IdleVec);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        w = 8'hB4;
        in_data = w;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b1, w[8-i], 1'b0, 1'b0, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL arst_pre cycle %0d: got %b want %b", i, got, exp);
            end
            if (i < 4) tick();
        end
        #2 reset = 1'b0;
        #1;
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL arst_immediate: got %b want %b", got, IdleVec);
        end
        @(negedge clk);
        reset = 1'b1;
        w = 8'h80;
        in_data = w;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            exp = {1'b1, (i <= 8) ? w[8-i] : 1'b1, i == FL, i == FL, 1'b1};
            got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL arst_80 cycle %0d: got %b want %b", i, got, exp);
            end
            tick();
        end
        got = {ovalid_m, bit_m, last_m, ready_m, busy_m};
        total++;
        if (got !== IdleVec) begin
            bad++;
            $display("FAIL arst_80_idle: got %b want %b", got, IdleVec);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_hold_off();
        test_parity();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detection path. Accepts one DATA_W-bit word per valid/ready handshake and emits it one bit per clock on out_bit/out_valid, which drive the Moore sequence detector's in_bit input directly. Words accepted back-to-back produce a continuous bit stream with no idle cycles.

## Interface
- DATA_W, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit DATA_W-1 first; 0 sends bit 0 first.

- clk, input, 1: single clock; all flops are rising-edge.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- in_data, input, DATA_W: parallel word; sampled only on the accept cycle.
- in_valid, input, 1: upstream has a word on in_data.
- in_ready, output, 1: serializer can take a word this cycle.
- out_bit, output, 1: current serial bit; drives the detector's in_bit.
- out_valid, output, 1: out_bit is meaningful this cycle.
- out_last, output, 1: out_bit is the final bit of the current frame.
- busy, output, 1: a frame is in progress; equals out_valid.

## Operation
- A word is accepted on any rising edge where in_valid && in_ready.
- States:
  - S_IDLE: no frame in flight.
  - S_SHIFT: data bits are being sent.
  - S_PARITY: the parity bit is being sent; exists only with the macro defined.
- Transitions:
  - S_IDLE -> S_SHIFT on accept.
  - S_SHIFT -> S_SHIFT while the bit counter < DATA_W-1.
  - On the last data bit: -> S_PARITY if parity is enabled. Otherwise -> S_SHIFT on a simultaneous accept, else -> S_IDLE.
  - S_PARITY -> S_SHIFT on a simultaneous accept, else -> S_IDLE.
- On accept:
  - Load the shift register from in_data.
  - Clear the bit counter (width $clog2(DATA_W)).
  - Clear the running parity.
- Each S_SHIFT cycle:
  - out_bit = shift register MSB when MSB_FIRST=1, LSB when MSB_FIRST=0.
  - The register shifts by one toward the output end.
  - The counter increments.
  - Parity XOR-accumulates out_bit.
- in_ready is high:
  - in S_IDLE;
  - on the final bit cycle of a frame (last data bit without parity, or the S_PARITY cycle).
- in_ready is low during all other S_SHIFT cycles. in_data and in_valid are ignored while in_ready is low; upstream must hold them.
- out_bit is driven 0 whenever out_valid is 0.
- There is no downstream backpressure: the detector consumes one bit every cycle.
- The counter never wraps mid-frame. It is reset on each accept.

## Timing
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0, state=S_IDLE, counter=0, shift register=0.
- Latency: a word accepted at edge k presents its first bit in the cycle after edge k.
- Frame length: DATA_W cycles, or DATA_W+1 cycles with parity enabled.
- Back-to-back accept: the next frame's first bit follows the previous frame's out_last cycle with no gap.
- in_ready is a registered-state decode. It must not depend combinationally on in_valid.
- Reset asserted mid-frame: all outputs go immediately to their reset values and the in-flight word is discarded. After release, the first accept is possible at the first rising edge.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - S_PARITY is compiled in.
  - After the last data bit, one extra bit carrying the even parity of the word is sent, with out_valid=1 and out_last=1.
  - out_last is 0 on the last data bit.
- Undefined:
  - No S_PARITY state and no parity logic.
  - out_last marks the last data bit.
  - The frame is exactly DATA_W cycles.

## Structure
- Shared package serializer_pkg holds:
  - typedef enum logic [1:0] ser_state_t {S_IDLE=2'b00, S_SHIFT=2'b01, S_PARITY=2'b10};
  - localparam SER_MAX_W = 32.
- Single module; no sub-module is warranted. The counter and shift register are inline.

## Test plan
All scenarios use DATA_W=8.

- MSB_FIRST=1, accept 8'hB4 at edge 0:
  - out_bit = 1,0,1,1,0,1,0,0 in cycles 1..8;
  - out_last only in cycle 8;
  - in_ready low in cycles 1..7.
- MSB_FIRST=0, accept 8'h01:
  - first bit 1, then seven 0s;
  - out_valid deasserts in cycle 9 when no new word is offered.
- Back-to-back: offer 8'hFF, then 8'h00 with in_valid held high:
  - 16 contiguous out_valid cycles: eight 1s then eight 0s;
  - the second accept occurs in cycle 8.
- SERIALIZER_PARITY_EN:
  - 8'hB4 gives 9 bits, with a parity bit of 0 in cycle 9 carrying out_last;
  - 8'h07 gives a parity bit of 1.
- Hold-off: in_valid high with 8'h55 during cycles 2..8 of a frame:
  - not accepted until in_ready rises;
  - 8'h55 is then emitted intact.
- Async reset: drive reset=0 in cycle 4 of frame 8'hB4:
  - out_valid=0 and in_ready=1 immediately;
  - after release, accepting 8'h80 emits 1,0,0,0,0,0,0,0.
